datapath_bus: RTL and testbench
===============================

// Module: datapath_bus
// PURPOSE
//  Register/bus datapath driven directly by the control FSM's alu_op/write_en/inc_en/clr_en/read_en.
//  Holds PC, AR, DR, IR, AC, R, R1-R4 (opt. R5), one shared bus, the ALU and its result latch.
//  Drives instruction memory (IM) and data memory (DM) ports; returns opcode and zero flag to control.
//  Acts on posedge clk; control updates its state on negedge, so all enables are stable at posedge.
// PARAMETERS
//  DATA_W   16  width of bus, all registers, memory data
//  ADDR_W   16  width of im_addr/dm_addr (low ADDR_W bits of PC/AR)
//  OP_W     6   opcode width presented on instruction
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  alu_op       in   3       0 pass,1 add,2 sub,3 mult,4 lshift
//  write_en     in   16      per-target load strobes (map below)
//  inc_en       in   16      bit1 PC+1, bit4 AC+1; others ignored
//  clr_en       in   16      bit1 PC<=0, bit2 AR<=0; others ignored
//  read_en      in   4       bus source select (map below)
//  im_rdata     in   DATA_W  IM read data, async w.r.t. im_addr
//  dm_rdata     in   DATA_W  DM read data, async w.r.t. dm_addr
//  im_addr      out  ADDR_W  = PC
//  dm_addr      out  ADDR_W  = AR
//  dm_wdata     out  DATA_W  = bus
//  dm_we        out  1       = write_en[11], combinational
//  instruction  out  OP_W    = IR[OP_W-1:0]
//  z            out  16      16'd1 when AC==0, else 16'd0 (registered view of AC)
//  bus_dbg      out  DATA_W  current bus value
// BEHAVIOUR
//  Bus (comb.): read_en 1 PC,2 AR,3 DR,4 IR,5 AC,6 R,7 R1,8 R2,9 R3,10 R4,11 R5,12 dm_rdata,13 im_rdata; 0,14,15 -> 0.
//  write_en: 1 PC,2 AR,3 IR,4 AC,5 R,6 R5,7 R4,8 R3,9 R2,10 R1,11 DM,12 AC<=alu_res,14 alu_res<=f(AC,R); others ignored.
//  Per-register priority at posedge: clr > write > inc. AC: write_en[4] (bus) beats write_en[12] (alu_res) beats inc.
//  DR <= dm_rdata on every cycle with read_en==12; otherwise holds.
//  ALU (comb. f, latched into alu_res only on write_en[14]): add AC+R, sub AC-R, mult low DATA_W of AC*R,
//   lshift AC<<R[3:0], pass/other codes -> AC. All mod 2^DATA_W; no carry kept.
//  alu_res is a register: 1-cycle latency; write_en[12] and [14] in same cycle -> AC gets OLD alu_res.
//  Increment wraps: PC/AC 16'hFFFF +1 -> 0. z follows AC after the same edge (no extra delay).
//  Simultaneous write to several targets from bus allowed; all get same bus value.
//  Reset (rst=1 at posedge): PC,AR,DR,IR,AC,R,R1-R5,alu_res <= 0; overrides every enable, incl. mid-instruction.
//  Outputs after reset: im_addr=0, dm_addr=0, instruction=0, z=16'd1, dm_we follows write_en[11] (comb.).
//  Unused enable bits (0,13,15) have no effect; X on them must not corrupt state.
// CONFIGURATION
//  DP_R5_EN defined: R5 implemented; write_en[6] loads bus, read_en 11 drives R5.
//  DP_R5_EN undefined: no R5 storage; write_en[6] ignored; read_en 11 drives 0.
// TESTING
//  Reset: hold rst 1 cycle with write_en=16'hFFFF -> all regs 0, z=1, im_addr=0.
//  Fetch: PC=5, im_rdata=16'h0013, read_en=13, write_en[3], inc_en[1] -> IR=16'h0013, instruction=6'd19, PC=6.
//  ALU: AC=7,R=3; op1 wr[14] then wr[12] -> AC=10; op2 -> AC=4; op3 AC=16'h8000,R=2 -> AC=0, z=1.
//  Wrap/priority: PC=16'hFFFF inc_en[1] -> PC=0; clr_en[1]+write_en[1]+inc_en[1] same cycle -> PC=0.
//  Store/load: AR=9, AC=16'h55AA, read_en=5, write_en[11] -> dm_we=1, dm_addr=9, dm_wdata=16'h55AA.
//  Option: with DP_R5_EN AC=3 -> R5, read_en=11 -> bus=3; without -> bus=0.

Source files
------------

// File: rtl/datapath_bus.sv
// Register/bus datapath: PC, AR, DR, IR, AC, R, R1-R4 (R5 with DP_R5_EN), shared bus, ALU and result latch.
// Define DP_R5_EN to implement R5 (loaded by write_en[6], read on read_en 11).
module datapath_bus #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        alu_op,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic [3:0]        read_en,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] im_addr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [OP_W-1:0]   instruction,
  output logic [15:0]       z,
  output logic [DATA_W-1:0] bus_dbg
);

`ifdef DP_R5_EN
  localparam int NUM_GPR = 5;
`else
  localparam int NUM_GPR = 4;
`endif

  logic [DATA_W-1:0] pc_q, ar_q, dr_q, ir_q, ac_q, r_q, alu_q;
  logic [DATA_W-1:0] pc_d, ar_d, dr_d, ir_d, ac_d, r_d, alu_d;
  logic [DATA_W-1:0] gpr_rd [1:NUM_GPR];
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_f;

  always_comb begin
    bus = '0;
    case (read_en)
      4'd1:  bus = pc_q;
      4'd2:  bus = ar_q;
      4'd3:  bus = dr_q;
      4'd4:  bus = ir_q;
      4'd5:  bus = ac_q;
      4'd6:  bus = r_q;
      4'd7:  bus = gpr_rd[1];
      4'd8:  bus = gpr_rd[2];
      4'd9:  bus = gpr_rd[3];
      4'd10: bus = gpr_rd[4];
`ifdef DP_R5_EN
      4'd11: bus = gpr_rd[5];
`endif
      4'd12: bus = dm_rdata;
      4'd13: bus = im_rdata;
      default: bus = '0;
    endcase
  end

  // Shift amount uses only R[3:0]; all results wrap to DATA_W.
  always_comb begin
    alu_f = ac_q;
    case (alu_op)
      3'd1: alu_f = ac_q + r_q;
      3'd2: alu_f = ac_q - r_q;
      3'd3: alu_f = DATA_W'(ac_q * r_q);
      3'd4: alu_f = ac_q << r_q[3:0];
      default: alu_f = ac_q;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (clr_en[1])        pc_d = '0;
    else if (write_en[1]) pc_d = bus;
    else if (inc_en[1])   pc_d = pc_q + DATA_W'(1);

    ar_d = ar_q;
    if (clr_en[2])        ar_d = '0;
    else if (write_en[2]) ar_d = bus;

    dr_d = (read_en == 4'd12) ? dm_rdata : dr_q;
    ir_d = write_en[3] ? bus : ir_q;
    r_d  = write_en[5] ? bus : r_q;

    // Bus load wins over the ALU latch; AC picks up alu_q as it was before this edge.
    ac_d = ac_q;
    if (write_en[4])       ac_d = bus;
    else if (write_en[12]) ac_d = alu_q;
    else if (inc_en[4])    ac_d = ac_q + DATA_W'(1);

    alu_d = write_en[14] ? alu_f : alu_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ar_q  <= '0;
      dr_q  <= '0;
      ir_q  <= '0;
      ac_q  <= '0;
      r_q   <= '0;
      alu_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ar_q  <= ar_d;
      dr_q  <= dr_d;
      ir_q  <= ir_d;
      ac_q  <= ac_d;
      r_q   <= r_d;
      alu_q <= alu_d;
    end
  end

  // Rk is loaded by write_en[11-k]: R1..R5 map to bits 10..6.
  genvar gi;
  generate
    for (gi = 1; gi <= NUM_GPR; gi++) begin : g_gpr
      logic [DATA_W-1:0] gpr_q;
      always_ff @(posedge clk) begin
        if (rst)                  gpr_q <= '0;
        else if (write_en[11-gi]) gpr_q <= bus;
      end
      assign gpr_rd[gi] = gpr_q;
    end
  endgenerate

  assign im_addr     = pc_q[ADDR_W-1:0];
  assign dm_addr     = ar_q[ADDR_W-1:0];
  assign dm_wdata    = bus;
  assign dm_we       = write_en[11];
  assign instruction = ir_q[OP_W-1:0];
  assign z           = (ac_q == '0) ? 16'd1 : 16'd0;
  assign bus_dbg     = bus;

  logic unused_en;
`ifdef DP_R5_EN
  assign unused_en = ^{write_en[0], write_en[13], write_en[15], inc_en[15:5], inc_en[3:2],
                       inc_en[0], clr_en[15:3], clr_en[0]};
`else
  assign unused_en = ^{write_en[0], write_en[6], write_en[13], write_en[15], inc_en[15:5],
                       inc_en[3:2], inc_en[0], clr_en[15:3], clr_en[0]};
`endif

endmodule

// File: tb/tb_datapath_bus.sv
// Self-checking bench for datapath_bus: directed scenarios plus randomized enables against a register-level model.
module tb_datapath_bus;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_op;
  logic [15:0] write_en, inc_en, clr_en;
  logic [3:0]  read_en;
  logic [15:0] im_rdata, dm_rdata;
  logic [15:0] im_addr, dm_addr, dm_wdata, z, bus_dbg;
  logic        dm_we;
  logic [5:0]  instruction;

  datapath_bus dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .write_en(write_en), .inc_en(inc_en),
    .clr_en(clr_en), .read_en(read_en), .im_rdata(im_rdata), .dm_rdata(dm_rdata),
    .im_addr(im_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z), .bus_dbg(bus_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference state: named registers, general registers indexed 1..5, ALU latch.
  logic [15:0] m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_alu;
  logic [15:0] m_g [1:5];
  bit          m_valid = 0;
  logic [15:0] last_bus, last_wdata;
  logic        last_we;

  function automatic logic [15:0] b(input int n);
    logic [15:0] one = 16'd1;
    return one << n;
  endfunction

  function automatic logic [15:0] model_bus(input logic [3:0] sel, input logic [15:0] imd, dmd);
    case (sel)
      1: return m_pc;   2: return m_ar;   3: return m_dr;   4: return m_ir;
      5: return m_ac;   6: return m_r;
      7, 8, 9, 10: return m_g[sel - 6];
`ifdef DP_R5_EN
      11: return m_g[5];
`endif
      12: return dmd;
      13: return imd;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] model_alu(input logic [2:0] op);
    case (op)
      1: return m_ac + m_r;
      2: return m_ac - m_r;
      3: return m_ac * m_r;
      4: return m_ac << m_r[3:0];
      default: return m_ac;
    endcase
  endfunction

  task automatic cycle(input logic r, input logic [2:0] op, input logic [15:0] we, inc, clr,
                       input logic [3:0] re, input logic [15:0] imd, dmd);
    logic [15:0] bv, fv;
    @(negedge clk);
    rst = r; alu_op = op; write_en = we; inc_en = inc; clr_en = clr;
    read_en = re; im_rdata = imd; dm_rdata = dmd;
    #1;
    last_bus = bus_dbg; last_we = dm_we; last_wdata = dm_wdata;
    bv = model_bus(re, imd, dmd);
    if (m_valid) begin
      chk("bus", bus_dbg, bv);
      chk("dm_wdata", dm_wdata, bv);
    end
    chk("dm_we", dm_we, we[11]);
    fv = model_alu(op);
    if (r) begin
      m_pc = 0; m_ar = 0; m_dr = 0; m_ir = 0; m_ac = 0; m_r = 0; m_alu = 0;
      for (int k = 1; k <= 5; k++) m_g[k] = 0;
      m_valid = 1;
    end else begin
      if (clr[1]) m_pc = 0; else if (we[1]) m_pc = bv; else if (inc[1]) m_pc = m_pc + 1;
      if (clr[2]) m_ar = 0; else if (we[2]) m_ar = bv;
      if (re == 12) m_dr = dmd;
      if (we[3]) m_ir = bv;
      if (we[4]) m_ac = bv; else if (we[12]) m_ac = m_alu; else if (inc[4]) m_ac = m_ac + 1;
      if (we[5]) m_r = bv;
      for (int k = 1; k <= 4; k++) if (we[11-k]) m_g[k] = bv;
`ifdef DP_R5_EN
      if (we[6]) m_g[5] = bv;
`endif
      if (we[14]) m_alu = fv;
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("im_addr", im_addr, m_pc);
      chk("dm_addr", dm_addr, m_ar);
      chk("instruction", instruction, m_ir[5:0]);
      chk("z", z, (m_ac == 0) ? 16'd1 : 16'd0);
    end
  endtask

  task automatic ld(input logic [15:0] we, input logic [15:0] val);
    cycle(1'b0, 3'd0, we, 16'd0, 16'd0, 4'd13, val, 16'($urandom));
  endtask

  task automatic rd(input logic [3:0] re);
    cycle(1'b0, 3'd0, 16'd0, 16'd0, 16'd0, re, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    rst = 1'b1; alu_op = 0; write_en = 0; inc_en = 0; clr_en = 0; read_en = 0;
    im_rdata = 0; dm_rdata = 0;

    // Reset overriding every enable
    cycle(1'b1, 3'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd13, 16'h1234, 16'h4321);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_z", z, 16'd1);
    for (int s = 1; s <= 11; s++) begin
      rd(4'(s));
      chk("rst_reg_zero", last_bus, 0);
    end

    // Fetch
    ld(b(1), 16'd5);
    cycle(1'b0, 3'd0, b(3), b(1), 16'd0, 4'd13, 16'h0013, 16'd0);
    chk("fetch_instr", instruction, 6'd19);
    chk("fetch_pc", im_addr, 16'd6);
    rd(4'd4);
    chk("fetch_ir", last_bus, 16'h0013);

    // ALU add / sub / mult
    ld(b(4), 16'd7); ld(b(5), 16'd3);
    cycle(1'b0, 3'd1, b(14), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    cycle(1'b0, 3'd0, b(12), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    rd(4'd5); chk("alu_add", last_bus, 16'd10);
    ld(b(4), 16'd7);
    cycle(1'b0, 3'd2, b(14), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    cycle(1'b0, 3'd0, b(12), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    rd(4'd5); chk("alu_sub", last_bus, 16'd4);
    ld(b(4), 16'h8000); ld(b(5), 16'd2);
    cycle(1'b0, 3'd3, b(14), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    cycle(1'b0, 3'd0, b(12), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    chk("alu_mult_z", z, 16'd1);

    // Latch and consume in one cycle: AC takes the old latch value
    ld(b(4), 16'd5); ld(b(5), 16'd1);
    cycle(1'b0, 3'd1, b(14), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    ld(b(4), 16'd20);
    cycle(1'b0, 3'd1, b(14) | b(12), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    rd(4'd5); chk("alu_old_res", last_bus, 16'd6);
    cycle(1'b0, 3'd0, b(12), 16'd0, 16'd0, 4'd0, 16'd0, 16'd0);
    rd(4'd5); chk("alu_new_res", last_bus, 16'd21);

    // Wrap and priority
    ld(b(1), 16'hFFFF);
    cycle(1'b0, 3'd0, 16'd0, b(1), 16'd0, 4'd0, 16'd0, 16'd0);
    chk("pc_wrap", im_addr, 16'd0);
    ld(b(1), 16'd7);
    cycle(1'b0, 3'd0, b(1), b(1), b(1), 4'd13, 16'h1234, 16'd0);
    chk("pc_clr_prio", im_addr, 16'd0);
    ld(b(4), 16'hFFFF);
    cycle(1'b0, 3'd0, 16'd0, b(4), 16'd0, 4'd0, 16'd0, 16'd0);
    chk("ac_wrap_z", z, 16'd1);

    // Store
    ld(b(2), 16'd9); ld(b(4), 16'h55AA);
    cycle(1'b0, 3'd0, b(11), 16'd0, 16'd0, 4'd5, 16'd0, 16'd0);
    chk("st_we", last_we, 1'b1);
    chk("st_wdata", last_wdata, 16'h55AA);
    chk("st_addr", dm_addr, 16'd9);

    // Load through DR
    cycle(1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 4'd12, 16'd0, 16'hABCD);
    rd(4'd3); chk("dr_load", last_bus, 16'hABCD);

    // Optional R5
    ld(b(4), 16'd3);
    cycle(1'b0, 3'd0, b(6), 16'd0, 16'd0, 4'd5, 16'd0, 16'd0);
    rd(4'd11);
`ifdef DP_R5_EN
    chk("r5_read", last_bus, 16'd3);
`else
    chk("r5_absent", last_bus, 16'd0);
`endif

    // Randomized enables, including noise on unused bits
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)),
            16'($urandom & $urandom), 16'($urandom & $urandom), 16'($urandom & $urandom & $urandom),
            4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
